// File: rtl/seq_pkg.sv
// Shared types and constants for the serial bit-stream transmitter.
// The optional pattern counter is enabled with SEQ_TX_MATCH_COUNT_EN.
package seq_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    GAP   = 2'd2
  } state_t;

  localparam logic [3:0] DEFAULT_PATTERN = 4'b1011;
  localparam int         MATCH_CNT_W     = 8;

  // Width of the len port: must be able to hold the value WIDTH itself.
  function automatic int len_width(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/seq_serial_tx_if.sv
// Load/serial bundle between a word source (master) and seq_serial_tx (slave).
interface seq_serial_tx_if
  import seq_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int LW    = len_width(WIDTH)
);

  // A word is taken on the rising edge where load and ready are both high;
  // ready never looks at load, and load while ready is low is simply dropped.
  logic [WIDTH-1:0]       din;
  logic [LW-1:0]          len;
  logic                   load;
  logic                   ready;
  logic                   x;
  logic                   x_valid;
  logic                   done;
  logic [MATCH_CNT_W-1:0] match_count;
  state_t                 dbg_state;

  modport master (
    output din, len, load,
    input  ready, x, x_valid, done, match_count, dbg_state
  );

  modport slave (
    input  din, len, load,
    output ready, x, x_valid, done, match_count, dbg_state
  );

endinterface

// File: rtl/seq_match_counter.sv
// Mealy matcher on the transmitted bit stream with a saturating occurrence count.
// Only instantiated when SEQ_TX_MATCH_COUNT_EN is defined.
module seq_match_counter
  import seq_pkg::*;
#(
  parameter int            PW      = 4,
  parameter logic [PW-1:0] PATTERN = DEFAULT_PATTERN
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   i_x,
  input  logic                   i_x_valid,
  output logic [MATCH_CNT_W-1:0] o_count
);

  localparam int             FW   = $clog2(PW);
  localparam logic [FW-1:0]  FULL = FW'(PW - 1);

  logic [PW-2:0]          r_hist;
  logic [FW-1:0]          r_fill;
  logic [MATCH_CNT_W-1:0] r_count;
  logic [PW-1:0]          w_window;
  logic                   w_hit;

  assign w_window = {r_hist, i_x};
  // History must hold PW-1 real bits before a window can match.
  assign w_hit    = i_x_valid && (r_fill == FULL) && (w_window == PATTERN);
  assign o_count  = r_count;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_hist  <= '0;
      r_fill  <= '0;
      r_count <= '0;
    end else if (!i_x_valid) begin
      r_hist <= '0;
      r_fill <= '0;
    end else begin
      r_hist <= w_window[PW-2:0];
      if (r_fill != FULL) begin
        r_fill <= r_fill + 1'b1;
      end
      if (w_hit && (r_count != '1)) begin
        r_count <= r_count + 1'b1;
      end
    end
  end

endmodule

// File: rtl/seq_serial_tx.sv
// Parallel-to-serial transmitter: MSB-first bits with a valid strobe and done pulse.
// Define SEQ_TX_MATCH_COUNT_EN to build the PATTERN occurrence counter.
module seq_serial_tx
  import seq_pkg::*;
#(
  parameter int         WIDTH      = 16,
  parameter int         GAP_CYCLES = 0,
  parameter logic       IDLE_LEVEL = 1'b0,
  parameter logic [3:0] PATTERN    = DEFAULT_PATTERN
) (
  input  logic         clk,
  input  logic         reset,
  seq_serial_tx_if.slave bus
);

  localparam int             LW       = len_width(WIDTH);
  localparam int             GW       = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;
  localparam logic [LW-1:0]  WIDTH_L  = LW'(WIDTH);
  localparam logic [GW-1:0]  GAP_LAST = (GAP_CYCLES > 0) ? GW'(GAP_CYCLES - 1) : '0;

  state_t                 r_state;
  logic [WIDTH-1:0]       r_shreg;
  logic [LW-1:0]          r_bits_left;
  logic [GW-1:0]          r_gap_cnt;
  logic                   r_x;
  logic                   r_x_valid;
  logic                   r_done;

  logic [LW-1:0]          w_len_eff;
  logic [WIDTH-1:0]       w_aligned;
  logic                   w_last_bit;
  logic                   w_ready;
  logic                   w_accept;
  logic [MATCH_CNT_W-1:0] w_match_count;

  // len of 0 or anything above WIDTH means a full-width word.
  assign w_len_eff  = ((bus.len == '0) || (bus.len > WIDTH_L)) ? WIDTH_L : bus.len;
  // Left-align so the first bit to send sits at the MSB of the shifter.
  assign w_aligned  = bus.din << (WIDTH_L - w_len_eff);
  assign w_last_bit = (r_state == SHIFT) && (r_bits_left == '0);
  assign w_ready    = (r_state == IDLE) || (w_last_bit && (GAP_CYCLES == 0));
  assign w_accept   = bus.load && w_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= IDLE;
      r_shreg     <= '0;
      r_bits_left <= '0;
      r_gap_cnt   <= '0;
      r_x         <= IDLE_LEVEL;
      r_x_valid   <= 1'b0;
      r_done      <= 1'b0;
    end else if (w_accept) begin
      r_state     <= SHIFT;
      r_x         <= w_aligned[WIDTH-1];
      r_x_valid   <= 1'b1;
      r_shreg     <= w_aligned << 1;
      r_bits_left <= w_len_eff - 1'b1;
      r_done      <= (w_len_eff == LW'(1));
    end else begin
      case (r_state)
        IDLE: begin
          r_x       <= IDLE_LEVEL;
          r_x_valid <= 1'b0;
          r_done    <= 1'b0;
        end
        SHIFT: begin
          if (r_bits_left == '0) begin
            r_x       <= IDLE_LEVEL;
            r_x_valid <= 1'b0;
            r_done    <= 1'b0;
            if (GAP_CYCLES > 0) begin
              r_state   <= GAP;
              r_gap_cnt <= GAP_LAST;
            end else begin
              r_state <= IDLE;
            end
          end else begin
            r_x         <= r_shreg[WIDTH-1];
            r_shreg     <= r_shreg << 1;
            r_bits_left <= r_bits_left - 1'b1;
            r_done      <= (r_bits_left == LW'(1));
          end
        end
        GAP: begin
          r_x       <= IDLE_LEVEL;
          r_x_valid <= 1'b0;
          r_done    <= 1'b0;
          if (r_gap_cnt == '0) begin
            r_state <= IDLE;
          end else begin
            r_gap_cnt <= r_gap_cnt - 1'b1;
          end
        end
        default: begin
          r_state   <= IDLE;
          r_x       <= IDLE_LEVEL;
          r_x_valid <= 1'b0;
          r_done    <= 1'b0;
        end
      endcase
    end
  end

`ifdef SEQ_TX_MATCH_COUNT_EN
  seq_match_counter #(
    .PW      (4),
    .PATTERN (PATTERN)
  ) u_match (
    .clk       (clk),
    .reset     (reset),
    .i_x       (r_x),
    .i_x_valid (r_x_valid),
    .o_count   (w_match_count)
  );
`else
  logic w_unused_pattern;
  assign w_unused_pattern = ^PATTERN;
  assign w_match_count    = '0;
`endif

  assign bus.ready       = w_ready;
  assign bus.x           = r_x;
  assign bus.x_valid     = r_x_valid;
  assign bus.done        = r_done;
  assign bus.match_count = w_match_count;
  assign bus.dbg_state   = r_state;

endmodule

// File: tb/tb_seq_serial_tx.sv
// Bench for seq_serial_tx: table of single words on a back-to-back instance,
// plus hand sequences for chaining, a GAP_CYCLES=2 instance, held load and reset.
module tb_seq_serial_tx;
  import seq_pkg::*;

  localparam int WIDTH = 16;
  localparam int LW    = len_width(WIDTH);
`ifdef SEQ_TX_MATCH_COUNT_EN
  localparam bit MC_EN = 1'b1;
`else
  localparam bit MC_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset;

  seq_serial_tx_if #(.WIDTH(WIDTH)) bus0 ();
  seq_serial_tx_if #(.WIDTH(WIDTH)) bus2 ();

  seq_serial_tx #(
    .WIDTH(WIDTH), .GAP_CYCLES(0), .IDLE_LEVEL(1'b0), .PATTERN(4'b1011)
  ) dut0 (
    .clk(clk), .reset(reset), .bus(bus0)
  );

  seq_serial_tx #(
    .WIDTH(WIDTH), .GAP_CYCLES(2), .IDLE_LEVEL(1'b0), .PATTERN(4'b1011)
  ) dut2 (
    .clk(clk), .reset(reset), .bus(bus2)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // scoreboard
  int   n_checks = 0;
  int   n_errors = 0;
  logic exp_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [15:0]   din;
    logic [LW-1:0] len;
    int            n;
    logic [15:0]   bits;
    logic [7:0]    mc;
  } vec_t;

  vec_t vecs[6];

  // driver tasks (entered and left just after a falling edge)
  task automatic wait_ready0();
    for (int i = 0; i < 50 && bus0.ready !== 1'b1; i++) @(negedge clk);
    check("ready0_wait", bus0.ready, 1'b1);
  endtask

  task automatic send0(input logic [15:0] din, input logic [LW-1:0] len);
    bus0.din  = din;
    bus0.len  = len;
    bus0.load = 1'b1;
    @(posedge clk);
    #1 bus0.load = 1'b0;
  endtask

  task automatic run_vec(input vec_t v, input logic [7:0] exp_mc);
    logic b;
    wait_ready0();
    send0(v.din, v.len);
    for (int k = 0; k < v.n; k++) exp_q.push_back(v.bits[v.n-1-k]);
    for (int k = 0; k < v.n; k++) begin
      @(negedge clk);
      b = exp_q.pop_front();
      check("vec_x", bus0.x, b);
      check("vec_x_valid", bus0.x_valid, 1'b1);
      check("vec_done", bus0.done, (k == v.n - 1));
      check("vec_ready", bus0.ready, (k == v.n - 1));
    end
    @(negedge clk);
    check("vec_idle_x", bus0.x, 1'b0);
    check("vec_idle_x_valid", bus0.x_valid, 1'b0);
    check("vec_idle_done", bus0.done, 1'b0);
    check("vec_match_count", bus0.match_count, MC_EN ? exp_mc : 8'd0);
  endtask

  initial begin
    logic [7:0]  seq_a;
    logic [7:0]  seq_c;
    logic [8:0]  g_x, g_xv, g_done, g_rdy;
    logic [15:0] w_d;

    vecs[0] = '{16'h2D96, 5'd0,  16, 16'h2D96, 8'd3};
    vecs[1] = '{16'hFFFF, 5'd1,  1,  16'h0001, 8'd3};
    vecs[2] = '{16'h00B6, 5'd8,  8,  16'h00B6, 8'd5};
    vecs[3] = '{16'h8001, 5'd20, 16, 16'h8001, 8'd5};
    vecs[4] = '{16'h1234, 5'd3,  3,  16'h0004, 8'd5};
    vecs[5] = '{16'hFFFE, 5'd1,  1,  16'h0000, 8'd5};

    bus0.din = '0; bus0.len = '0; bus0.load = 1'b0;
    bus2.din = '0; bus2.len = '0; bus2.load = 1'b0;
    reset = 1'b1;
    #15 reset = 1'b0;
    @(negedge clk);

    check("rst_x", bus0.x, 1'b0);
    check("rst_x_valid", bus0.x_valid, 1'b0);
    check("rst_done", bus0.done, 1'b0);
    check("rst_ready", bus0.ready, 1'b1);
    check("rst_state", bus0.dbg_state, IDLE);
    check("rst_match_count", bus0.match_count, 8'd0);
    check("rst2_x_valid", bus2.x_valid, 1'b0);
    check("rst2_ready", bus2.ready, 1'b1);

    for (int i = 0; i < 6; i++) run_vec(vecs[i], vecs[i].mc);

    // Second word accepted in the first word's last-bit cycle: no bubble.
    seq_a = 8'b10110110;
    wait_ready0();
    send0(16'h000B, 5'd4);
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (k == 4) bus0.load = 1'b0;
      check("chain_x", bus0.x, seq_a[7-k]);
      check("chain_x_valid", bus0.x_valid, 1'b1);
      check("chain_done", bus0.done, (k == 3 || k == 7));
      check("chain_ready", bus0.ready, (k == 3 || k == 7));
      if (k == 3) begin
        bus0.din  = 16'h0006;
        bus0.len  = 5'd4;
        bus0.load = 1'b1;
      end
    end
    @(negedge clk);
    check("chain_end_x_valid", bus0.x_valid, 1'b0);
    check("chain_match_count", bus0.match_count, MC_EN ? 8'd7 : 8'd0);

    // load held with different data while shifting must not disturb the word.
    seq_c = 8'b11110000;
    wait_ready0();
    send0(16'h00F0, 5'd8);
    bus0.din  = 16'h5555;
    bus0.len  = 5'd2;
    bus0.load = 1'b1;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (k == 6) bus0.load = 1'b0;
      check("hold_x", bus0.x, seq_c[7-k]);
      check("hold_done", bus0.done, (k == 7));
    end
    @(negedge clk);
    check("hold_end_x_valid", bus0.x_valid, 1'b0);
    check("hold_match_count", bus0.match_count, MC_EN ? 8'd7 : 8'd0);

    // GAP_CYCLES=2 instance with load held high across two words.
    g_x    = 9'b101000101;
    g_xv   = 9'b111000111;
    g_done = 9'b001000001;
    g_rdy  = 9'b000001000;
    check("gap_ready_start", bus2.ready, 1'b1);
    bus2.din  = 16'h0005;
    bus2.len  = 5'd3;
    bus2.load = 1'b1;
    @(posedge clk);
    for (int k = 0; k < 9; k++) begin
      @(negedge clk);
      check("gap_x", bus2.x, g_x[8-k]);
      check("gap_x_valid", bus2.x_valid, g_xv[8-k]);
      check("gap_done", bus2.done, g_done[8-k]);
      check("gap_ready", bus2.ready, g_rdy[8-k]);
    end
    bus2.load = 1'b0;
    @(negedge clk);
    check("gap_end_x_valid", bus2.x_valid, 1'b0);
    check("gap_end_ready", bus2.ready, 1'b0);
    check("gap_match_count", bus2.match_count, 8'd0);

    // Reset in bit 5 of a 16-bit word aborts it at once.
    w_d = 16'h2D96;
    wait_ready0();
    send0(16'h2D96, 5'd0);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("abort_x", bus0.x, w_d[15-k]);
    end
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("abort_x_idle", bus0.x, 1'b0);
    check("abort_x_valid", bus0.x_valid, 1'b0);
    check("abort_done", bus0.done, 1'b0);
    check("abort_match_count", bus0.match_count, 8'd0);
    check("abort_ready", bus0.ready, 1'b1);
    @(negedge clk);
    check("abort_hold_x_valid", bus0.x_valid, 1'b0);
    check("abort_hold_done", bus0.done, 1'b0);
    reset = 1'b0;
    run_vec(vecs[1], 8'd0);
    run_vec(vecs[2], 8'd2);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
